// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data-stage requesters
module mem_port_arbiter #(
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IReqF,
    input  logic [31:0] IAddrF,
    output logic [31:0] IRdataF,
    output logic        IValidF,
    input  logic        DReqM,
    input  logic        DWeM,
    input  logic [31:0] DAddrM,
    input  logic [31:0] DWdataM,
    input  logic [3:0]  DBeM,
    output logic [31:0] DRdataM,
    output logic        DValidM,
    output logic        IStall,
    output logic        DStall,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    output logic [3:0]  MemBe,
    input  logic        MemReady,
    input  logic [31:0] MemRdata,
    output logic        BusErr
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

    localparam int            SW         = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [15:0]   TMO_LAST   = 16'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [15:0]   tmo_q, tmo_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          i_valid_q, i_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          bus_err_q, bus_err_d;
    logic          data_win;
    logic          finish;
    logic [31:0]   result;

    // Data wins unless the fetch side has already been passed over STARVE_LIMIT times
    assign data_win = DReqM && (!IReqF || starve_q < STARVE_MAX);
    // A ready response beats the timeout when both land on the same cycle
    assign finish   = MemReady || tmo_q == TMO_LAST;
    assign result   = (MemReady && !mem_we_q) ? MemRdata : 32'h0;

    // Next-state and command/result register computation
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_win) begin
                    state_d     = DBUSY;
                    tmo_d       = '0;
                    mem_we_d    = DWeM;
                    mem_addr_d  = DAddrM;
                    mem_wdata_d = DWdataM;
                    mem_be_d    = DBeM;
                    starve_d    = IReqF ? starve_q + 1'b1 : starve_q;
                end else if (IReqF) begin
                    state_d     = IBUSY;
                    tmo_d       = '0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = IAddrF;
                    mem_wdata_d = 32'h0;
                    mem_be_d    = 4'hF;
                    starve_d    = '0;
                end
            end
            IBUSY, DBUSY: begin
                if (finish) begin
                    state_d   = DONE;
                    bus_err_d = !MemReady;
                    i_valid_d = state_q == IBUSY;
                    d_valid_d = state_q == DBUSY;
                    i_rdata_d = (state_q == IBUSY) ? result : i_rdata_q;
                    d_rdata_d = (state_q == DBUSY) ? result : d_rdata_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_valid_q   <= i_valid_d;
            d_valid_q   <= d_valid_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign MemReq   = state_q == IBUSY || state_q == DBUSY;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign MemBe    = mem_be_q;
    assign IRdataF  = i_rdata_q;
    assign DRdataM  = d_rdata_q;
    assign IValidF  = i_valid_q;
    assign DValidM  = d_valid_q;
    assign BusErr   = bus_err_q;
    assign IStall   = IReqF & ~IValidF;
    assign DStall   = DReqM & ~DValidM;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and randomized model check
module tb_mem_port_arbiter;
    localparam int TMO = 8;
    localparam int SL  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IReqF = 1'b0;
    logic [31:0] IAddrF = '0;
    logic [31:0] IRdataF;
    logic        IValidF;
    logic        DReqM = 1'b0;
    logic        DWeM = 1'b0;
    logic [31:0] DAddrM = '0;
    logic [31:0] DWdataM = '0;
    logic [3:0]  DBeM = '0;
    logic [31:0] DRdataM;
    logic        DValidM;
    logic        IStall;
    logic        DStall;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [3:0]  MemBe;
    logic        MemReady = 1'b0;
    logic [31:0] MemRdata = '0;
    logic        BusErr;

    mem_port_arbiter #(.TIMEOUT(TMO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(IRdataF), .IValidF(IValidF),
        .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM), .DBeM(DBeM),
        .DRdataM(DRdataM), .DValidM(DValidM), .IStall(IStall), .DStall(DStall),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemBe(MemBe),
        .MemReady(MemReady), .MemRdata(MemRdata), .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          rdy;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vt [8];

    // Reference model: transaction-level view of the port
    int          m_ph;
    int          m_age;
    int          m_starve;
    logic        m_d, m_we, m_ival, m_dval, m_err;
    logic [31:0] m_addr, m_wdata, m_ires, m_dres;
    logic [3:0]  m_be;

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_starve = 0;
        m_d = 0; m_we = 0; m_ival = 0; m_dval = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_ires = 0; m_dres = 0; m_be = 0;
    endtask

    task automatic model_step();
        logic [31:0] res;
        m_ival = 0; m_dval = 0; m_err = 0;
        if (m_ph == 0) begin
            if (DReqM && (!IReqF || m_starve < SL)) begin
                m_d = 1; m_we = DWeM; m_addr = DAddrM; m_wdata = DWdataM; m_be = DBeM;
                if (IReqF) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
                m_ph = 1; m_age = 0;
            end else if (IReqF) begin
                m_d = 0; m_we = 0; m_addr = IAddrF; m_wdata = 0; m_be = 4'hF;
                m_starve = 0; m_ph = 1; m_age = 0;
            end
        end else if (m_ph == 1) begin
            m_age++;
            if (MemReady || m_age == TMO) begin
                res = (MemReady && !m_we) ? MemRdata : 32'h0;
                if (m_d) begin m_dres = res; m_dval = 1; end
                else begin m_ires = res; m_ival = 1; end
                m_err = !MemReady;
                m_ph = 2;
            end
        end else begin
            m_ph = 0;
        end
    endtask

    initial begin
        string       order;
        logic [31:0] exp_addr;
        int          pcts [4];
        int          pct;
        bit          f_act, d_act;

        vt[0] = '{1'b0, 1'b0, 32'h100,  32'h12345678, 4'h0,    32'h00500093, 1, 1'b0, 32'h0,        4'hF,    32'h00500093, 1'b0};
        vt[1] = '{1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, 32'hCAFEF00D, 3, 1'b1, 32'hDEADBEEF, 4'b0011, 32'h0,        1'b0};
        vt[2] = '{1'b1, 1'b0, 32'h3004, 32'hAAAA5555, 4'hF,    32'h11223344, 1, 1'b0, 32'hAAAA5555, 4'hF,    32'h11223344, 1'b0};
        vt[3] = '{1'b1, 1'b0, 32'h3008, 32'h0,        4'h5,    32'h99887766, 0, 1'b0, 32'h0,        4'h5,    32'h0,        1'b1};
        vt[4] = '{1'b1, 1'b0, 32'h300C, 32'h1,        4'hC,    32'h0BADCAFE, 8, 1'b0, 32'h1,        4'hC,    32'h0BADCAFE, 1'b0};
        vt[5] = '{1'b0, 1'b0, 32'h104,  32'hFFFFFFFF, 4'h3,    32'h55555555, 0, 1'b0, 32'h0,        4'hF,    32'h0,        1'b1};
        vt[6] = '{1'b0, 1'b0, 32'h108,  32'h0,        4'h0,    32'h13579BDF, 2, 1'b0, 32'h0,        4'hF,    32'h13579BDF, 1'b0};
        vt[7] = '{1'b1, 1'b1, 32'h2004, 32'h01020304, 4'b1000, 32'hFFFF0000, 8, 1'b1, 32'h01020304, 4'b1000, 32'h0,        1'b0};

        #12;
        chk("reset state", {MemReq, MemWe, MemAddr, MemWdata, MemBe, IValidF, DValidM, IRdataF, DRdataM, BusErr, IStall, DStall}, '0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            vec_t v;
            int n;
            v = vt[i];
            n = (v.rdy == 0) ? TMO : v.rdy;
            IReqF = !v.d; IAddrF = v.addr;
            DReqM = v.d; DWeM = v.we; DAddrM = v.addr; DWdataM = v.wdata; DBeM = v.be;
            MemRdata = v.rdata; MemReady = 1'b0;
            for (int k = 1; k <= n; k++) begin
                tick();
                MemReady = (k == v.rdy);
                chk($sformatf("v%0d busy%0d", i, k),
                    {MemReq, IValidF, DValidM, BusErr, IStall, DStall, MemWe, MemAddr, MemWdata, MemBe},
                    {4'b1000, !v.d, v.d, v.exp_we, v.addr, v.exp_wdata, v.exp_be});
            end
            tick();
            MemReady = 1'b0;
            chk($sformatf("v%0d done flags", i), {IValidF, DValidM, BusErr, MemReq, IStall, DStall},
                {!v.d, v.d, v.exp_err, 3'b000});
            chk($sformatf("v%0d result", i), v.d ? DRdataM : IRdataF, v.exp_res);
            IReqF = 1'b0; DReqM = 1'b0;
            tick();
            chk($sformatf("v%0d after", i), {IValidF, DValidM, BusErr, MemReq, v.d ? DRdataM : IRdataF},
                {4'b0000, v.exp_res});
        end

        IReqF = 1'b1; IAddrF = 32'h400;
        DReqM = 1'b1; DAddrM = 32'h500; DWeM = 1'b0; DBeM = 4'hF;
        MemReady = 1'b1; MemRdata = 32'h77;
        tick();
        chk("simul first", {MemReq, MemAddr}, {1'b1, 32'h500});
        tick();
        chk("simul dvalid", {DValidM, IValidF}, 2'b10);
        DReqM = 1'b0;
        tick();
        tick();
        chk("simul second", {MemReq, MemWe, MemAddr}, {2'b10, 32'h400});
        tick();
        chk("simul ivalid", {DValidM, IValidF, IRdataF}, {2'b01, 32'h77});
        tick();

        DReqM = 1'b1;
        order = "DDDDID";
        for (int t = 0; t < 6; t++) begin
            tick();
            exp_addr = (order[t] == "D") ? 32'h500 : 32'h400;
            chk($sformatf("starve grant%0d", t), {MemReq, MemAddr}, {1'b1, exp_addr});
            tick();
            tick();
        end
        IReqF = 1'b0; DReqM = 1'b0; MemReady = 1'b0;
        tick();

        DReqM = 1'b1; DAddrM = 32'h600;
        tick();
        tick();
        chk("rst busy", {MemReq, MemAddr}, {1'b1, 32'h600});
        #2 rst_n = 1'b0;
        DReqM = 1'b0;
        #1;
        chk("rst async", {MemReq, MemWe, MemAddr, MemWdata, MemBe, IValidF, DValidM, IRdataF, DRdataM, BusErr}, '0);
        @(negedge clk) rst_n = 1'b1;
        MemReady = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk($sformatf("rst ignore%0d", t), {MemReq, IValidF, DValidM, BusErr}, 4'b0000);
        end
        MemReady = 1'b0;

        rst_n = 1'b0;
        IReqF = 1'b0; DReqM = 1'b0;
        model_reset();
        f_act = 0; d_act = 0;
        pcts = '{60, 15, 0, 100};
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rand c%0d", c),
                {MemReq, MemWe, MemAddr, MemWdata, MemBe, IValidF, DValidM, IRdataF, DRdataM, BusErr, IStall, DStall},
                {m_ph == 1, m_we, m_addr, m_wdata, m_be, m_ival, m_dval, m_ires, m_dres, m_err,
                 IReqF & ~m_ival, DReqM & ~m_dval});
            if (!f_act || m_ival) begin
                f_act = $urandom_range(0, 2) != 0;
                IReqF = f_act;
                IAddrF = $urandom;
            end
            if (!d_act || m_dval) begin
                d_act = $urandom_range(0, 2) != 0;
                DReqM = d_act;
                DWeM = 1'($urandom_range(0, 1));
                DAddrM = $urandom;
                DWdataM = $urandom;
                DBeM = 4'($urandom);
            end
            pct = pcts[(c / 400) % 4];
            MemReady = $urandom_range(0, 99) < pct;
            MemRdata = $urandom;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles in a BUSY state before forced completion (legal 2..65535).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while IReqF is pending.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports IReqF in 1, fetch request; IAddrF in 32, fetch address.
REQ-006 SHALL have ports IRdataF out 32, fetch data; IValidF out 1, fetch completion pulse.
REQ-007 SHALL have ports DReqM in 1, DWeM in 1, DAddrM in 32, DWdataM in 32, DBeM in 4: data-stage request, write enable, address, write data, byte enables.
REQ-008 SHALL have ports DRdataM out 32, data read result; DValidM out 1, data completion pulse.
REQ-009 SHALL have ports IStall out 1 and DStall out 1: stall requests to the hazard logic.
REQ-010 SHALL have ports MemReq out 1, MemWe out 1, MemAddr out 32, MemWdata out 32, MemBe out 4 (memory command) and MemReady in 1, MemRdata in 32 (memory response).
REQ-011 SHALL have port BusErr  output  1  one-cycle pulse on timeout completion.

Function
REQ-012 SHALL implement FSM states IDLE, IBUSY, DBUSY, DONE.
REQ-013 IDLE: grant data if DReqM=1 and (IReqF=0 or starve_cnt<STARVE_LIMIT); else grant fetch if IReqF=1; else stay IDLE.
REQ-014 Grant SHALL latch addr/we/wdata/be of the winner into command registers at the grant edge; fetch grant forces MemWe=0, MemBe=4'hF, MemWdata=0.
REQ-015 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each data grant with IReqF=1, clear on each fetch grant, hold otherwise.
REQ-016 MemReq SHALL be 1 exactly in IBUSY/DBUSY; MemWe/MemAddr/MemWdata/MemBe SHALL hold stable throughout BUSY.
REQ-017 BUSY -> DONE on the edge where MemReady=1 is sampled; result register loads MemRdata (fetch or data read) or 0 (data write).
REQ-018 Timeout counter SHALL clear on grant, increment each BUSY cycle; if it reaches TIMEOUT-1 with MemReady=0, BUSY -> DONE with result 0 and BusErr=1 during DONE.
REQ-019 MemReady=1 on the timeout cycle SHALL win: normal completion, no BusErr.
REQ-020 DONE SHALL last exactly one cycle, assert IValidF (fetch) or DValidM (data) plus IRdataF/DRdataM = result, then go to IDLE; no grant is evaluated in DONE.
REQ-021 Outside DONE, IValidF=DValidM=0 and IRdataF/DRdataM SHALL hold last result.
REQ-022 MemReady in IDLE or DONE SHALL be ignored.
REQ-023 IStall = IReqF & ~IValidF; DStall = DReqM & ~DValidM (combinational).
REQ-024 Requesters SHALL hold Req and operands stable until their Valid pulse; arbiter need not tolerate request withdrawal mid-BUSY (completes it regardless).
REQ-025 Minimum latency: request seen at edge N -> Valid high in cycle N+2 with single-cycle MemReady; one transaction per 3 cycles maximum.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, MemReq=0, MemWe=0, MemAddr=0, MemWdata=0, MemBe=0, IValidF=DValidM=0, IRdataF=DRdataM=0, BusErr=0, starve_cnt=0, timeout counter 0.
REQ-027 Reset mid-BUSY SHALL abandon the transaction; a MemReady arriving after release SHALL be ignored (IDLE).

Verification
REQ-028 Single fetch: IReqF=1, IAddrF=0x100, MemReady=1 one cycle after MemReq, MemRdata=0x00500093 -> MemAddr=0x100, IValidF pulse, IRdataF=0x00500093, IStall low in Valid cycle.
REQ-029 Simultaneous: IReqF=DReqM=1 in IDLE -> data granted first; fetch granted in the following IDLE.
REQ-030 Starvation: IReqF held, DReqM held through 6 transactions, STARVE_LIMIT=4 -> grants D,D,D,D,I,D.
REQ-031 Write: DReqM=DWeM=1, DAddrM=0x2000, DWdataM=0xDEADBEEF, DBeM=4'b0011 -> MemWe=1, MemBe=4'b0011, fields stable until MemReady; DRdataM=0.
REQ-032 Timeout: TIMEOUT=8, MemReady never asserted -> DONE after 8 BUSY cycles, DValidM=1, DRdataM=0, BusErr one-cycle pulse; repeat with MemReady on cycle 8 -> BusErr=0.
REQ-033 Reset mid-BUSY: rst_n low during DBUSY -> MemReq=0 asynchronously; MemReady after release produces no Valid.
